uart_rx_framer: RTL

Sequences the byte stream from the UART receive line into framed order-entry messages for the trading engine.
- Frame format: sync 0xA5, opcode, length, 0..MAX_LEN payload bytes, XOR checksum.
- Validated messages go downstream on a valid/ready handshake.
- Malformed frames are dropped with single-cycle error pulses.

---
 rtl/uart_rx_framer.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_framer.sv
// Frames the UART byte stream (sync, opcode, length, payload, XOR checksum) into held messages.
// Define FRAMER_STATS_EN to add saturating accepted-frame and error counters with a synchronous clear.
module uart_rx_framer #(
    parameter int          MAX_LEN        = 8,
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [7:0]             msg_opcode,
    output logic [3:0]             msg_len,
    output logic [8*MAX_LEN-1:0]   msg_payload,
    output logic                   msg_valid,
    input  logic                   msg_ready,
    output logic                   err_checksum,
    output logic                   err_length,
    output logic                   err_timeout,
    output logic                   err_overrun,
    output logic                   busy
`ifdef FRAMER_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [15:0]            stat_frames,
    output logic [15:0]            stat_errors
`endif
);

    localparam int               TW        = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]    TMO_LAST  = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {HUNT, OPCODE, LEN, PAYLOAD, CSUM, HOLD} state_t;

    state_t         state_reg, state_next;
    logic [7:0]     csum_reg;
    logic [3:0]     idx_reg;
    logic [TW-1:0]  tmo_reg;
    logic [7:0]     opcode_reg;
    logic [3:0]     len_reg;
    logic           err_checksum_reg, err_length_reg, err_timeout_reg, err_overrun_reg;
    logic           err_checksum_next, err_length_next, err_timeout_next, err_overrun_next;

    logic rx_sync, accept, frame_start, timing_state, tmo_expire;

    // A sync byte arriving on the accept cycle is treated as if already back in HUNT.
    assign rx_sync      = rx_valid && (rx_data == SYNC_BYTE);
    assign accept       = (state_reg == HOLD) && msg_ready;
    assign frame_start  = rx_sync && ((state_reg == HUNT) || accept);
    assign timing_state = (state_reg == OPCODE) || (state_reg == LEN) ||
                          (state_reg == PAYLOAD) || (state_reg == CSUM);
    // Expiry fires on the edge where the counter would reach TIMEOUT_CYCLES-1; a byte then wins.
    assign tmo_expire   = timing_state && !rx_valid && (tmo_reg == TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= HUNT;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next        = state_reg;
        err_checksum_next = 1'b0;
        err_length_next   = 1'b0;
        err_timeout_next  = 1'b0;
        err_overrun_next  = 1'b0;
        case (state_reg)
            HUNT:    if (rx_sync) state_next = OPCODE;
            OPCODE:  if (rx_valid) state_next = LEN;
            LEN: begin
                if (rx_valid) begin
                    if (rx_data > MAX_LEN_B) begin
                        state_next      = HUNT;
                        err_length_next = 1'b1;
                    end else if (rx_data == 8'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: if (rx_valid && (idx_reg == len_reg - 4'd1)) state_next = CSUM;
            CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_reg) begin
                        state_next = HOLD;
                    end else begin
                        state_next        = HUNT;
                        err_checksum_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (msg_ready)     state_next = rx_sync ? OPCODE : HUNT;
                else if (rx_valid) err_overrun_next = 1'b1;
            end
            default: state_next = HUNT;
        endcase
        if (tmo_expire) begin
            state_next       = HUNT;
            err_timeout_next = 1'b1;
        end
    end

    always_comb begin
        msg_valid = (state_reg == HOLD);
        busy      = (state_reg != HUNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_reg         <= '0;
            idx_reg          <= '0;
            tmo_reg          <= '0;
            opcode_reg       <= '0;
            len_reg          <= '0;
            err_checksum_reg <= 1'b0;
            err_length_reg   <= 1'b0;
            err_timeout_reg  <= 1'b0;
            err_overrun_reg  <= 1'b0;
        end else begin
            err_checksum_reg <= err_checksum_next;
            err_length_reg   <= err_length_next;
            err_timeout_reg  <= err_timeout_next;
            err_overrun_reg  <= err_overrun_next;
            if (timing_state) tmo_reg <= rx_valid ? '0 : tmo_reg + 1'b1;
            else              tmo_reg <= '0;
            if (frame_start) begin
                csum_reg <= '0;
                idx_reg  <= '0;
            end else if (rx_valid) begin
                case (state_reg)
                    OPCODE: begin
                        opcode_reg <= rx_data;
                        csum_reg   <= csum_reg ^ rx_data;
                    end
                    LEN: begin
                        if (rx_data <= MAX_LEN_B) begin
                            len_reg  <= rx_data[3:0];
                            csum_reg <= csum_reg ^ rx_data;
                        end
                    end
                    PAYLOAD: begin
                        csum_reg <= csum_reg ^ rx_data;
                        idx_reg  <= idx_reg + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_payload
            logic [7:0] byte_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    byte_reg <= '0;
                else if (frame_start)
                    byte_reg <= '0;
                else if ((state_reg == PAYLOAD) && rx_valid && (idx_reg == 4'(gi)))
                    byte_reg <= rx_data;
            end
            assign msg_payload[8*gi +: 8] = byte_reg;
        end
    endgenerate

    assign msg_opcode   = opcode_reg;
    assign msg_len      = len_reg;
    assign err_checksum = err_checksum_reg;
    assign err_length   = err_length_reg;
    assign err_timeout  = err_timeout_reg;
    assign err_overrun  = err_overrun_reg;

`ifdef FRAMER_STATS_EN
    logic [15:0] stat_frames_reg, stat_errors_reg;
    logic        any_err_next;

    assign any_err_next = err_checksum_next | err_length_next | err_timeout_next | err_overrun_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_frames_reg <= '0;
            stat_errors_reg <= '0;
        end else if (stat_clr) begin
            stat_frames_reg <= '0;
            stat_errors_reg <= '0;
        end else begin
            if (accept && (stat_frames_reg != 16'hFFFF))       stat_frames_reg <= stat_frames_reg + 16'd1;
            if (any_err_next && (stat_errors_reg != 16'hFFFF)) stat_errors_reg <= stat_errors_reg + 16'd1;
        end
    end

    assign stat_frames = stat_frames_reg;
    assign stat_errors = stat_errors_reg;
`endif

endmodule
